// File: rtl/router_sync.sv
// router_sync: address latch, write-enable steering and per-port read
// timeout for the three router_fifo instances downstream of it.
// Optional build macro ROUTER_SYNC_ADDR_ERR_EN adds a registered addr_err
// flag that blocks all FIFO writes after a header carrying address 11.
module router_sync #(
    parameter int TIMEOUT = 30, // unread-valid cycles before soft_reset (2..63)
    parameter int CNT_W   = 6   // timeout counter width, 2**CNT_W > TIMEOUT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    ,
    output logic       addr_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr;
    logic             writes_blocked;
    logic [2:0]       vld;
    logic [2:0]       rd;
    logic [2:0]       sr;
    logic [CNT_W-1:0] cnt [3];

    // Destination address register, loaded from the header byte.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetn) begin
            addr <= 2'b00;
        end else if (detect_add) begin
            addr <= data_in;
        end
    end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    // Illegal-address flag: set by a header to port 11, cleared by a legal one.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_err <= (data_in == 2'b11);
        end
    end

    assign writes_blocked = addr_err;
`else
    assign writes_blocked = 1'b0;
`endif

    // Steer the write strobe and full flag from the registered address;
    // a same-cycle detect_add therefore still uses the old address.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        write_enb = 3'b000;
        fifo_full = 1'b0;
        if (!writes_blocked) begin
            unique case (addr)
                2'b00: begin
                    write_enb = {2'b00, write_enb_reg};
                    fifo_full = full_0;
                end
                2'b01: begin
                    write_enb = {1'b0, write_enb_reg, 1'b0};
                    fifo_full = full_1;
                end
                2'b10: begin
                    write_enb = {write_enb_reg, 2'b00};
                    fifo_full = full_2;
                end
                default: begin
                    write_enb = 3'b000;
                    fifo_full = 1'b0;
                end
            endcase
        end
    end

    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar g = 0; g < 3; g++) begin : g_port
        // Count consecutive valid-but-unread cycles; pulse soft_reset once
        // when the window expires, then start a fresh window.
        always_ff @(posedge clock) begin
            if (!resetn || !vld[g] || rd[g]) begin
                cnt[g] <= '0;
                sr[g]  <= 1'b0;
            end else if (cnt[g] == CNT_LAST) begin
                cnt[g] <= '0;
                sr[g]  <= 1'b1;
            end else begin
                cnt[g] <= cnt[g] + CNT_W'(1);
                sr[g]  <= 1'b0;
            end
        end
    end

    assign vld_out_0    = vld[0];
    assign vld_out_1    = vld[1];
    assign vld_out_2    = vld[2];
    assign soft_reset_0 = sr[0];
    assign soft_reset_1 = sr[1];
    assign soft_reset_2 = sr[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync (default TIMEOUT=30).
module tb_router_sync;

    localparam int TO = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       detect_add = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       write_enb_reg = 1'b0;
    logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
    logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
    logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic       addr_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    router_sync #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .full_0(full_0), .full_1(full_1), .full_2(full_2),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        , .addr_err(addr_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_addr(input logic [1:0] a);
        detect_add    = 1'b1;
        data_in       = a;
        write_enb_reg = 1'b0;
        step();
        detect_add    = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        write_enb_reg = 1'b1;
        step();
        resetn = 1'b1;
        #1;
        check("reset_wenb_addr00", {1'b0, write_enb}, 4'h1);
        check("reset_soft_reset", {1'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 4'h0);
        check("reset_vld_out", {1'b0, vld_out_2, vld_out_1, vld_out_0}, 4'h0);

        // Address steering
        load_addr(2'b01);
        check("wenb_reg0", {1'b0, write_enb}, 4'h0);
        write_enb_reg = 1'b1; #1;
        check("steer_01", {1'b0, write_enb}, 4'h2);
        load_addr(2'b10);
        write_enb_reg = 1'b1; #1;
        check("steer_10", {1'b0, write_enb}, 4'h4);
        load_addr(2'b00);
        write_enb_reg = 1'b1; #1;
        check("steer_00", {1'b0, write_enb}, 4'h1);
        load_addr(2'b11);
        write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
        check("steer_11", {1'b0, write_enb}, 4'h0);
        check("full_addr11", {3'b0, fifo_full}, 4'h0);
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

        // Same-cycle detect_add and write strobe decode the old address
        load_addr(2'b00);
        detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; #1;
        check("same_cycle_old", {1'b0, write_enb}, 4'h1);
        step();
        detect_add = 1'b0; #1;
        check("same_cycle_new", {1'b0, write_enb}, 4'h4);

        // fifo_full mux
        load_addr(2'b01);
        full_1 = 1'b1; #1;
        check("full_addr01", {3'b0, fifo_full}, 4'h1);
        load_addr(2'b10);
        check("full_addr10", {3'b0, fifo_full}, 4'h0);
        full_2 = 1'b1; #1;
        check("full_addr10_set", {3'b0, fifo_full}, 4'h1);
        full_1 = 1'b0; full_2 = 1'b0;

        // vld_out follows ~empty immediately
        empty_1 = 1'b0; #1;
        check("vld_out_1", {1'b0, vld_out_2, vld_out_1, vld_out_0}, 4'h2);
        empty_1 = 1'b1; #1;

        // Timeout on port 2: pulse after edges 30 and 60
        empty_2 = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            step();
            check($sformatf("timeout2_e%0d", k), {3'b0, soft_reset_2},
                  {3'b0, (k == TO || k == 2 * TO)});
        end
        empty_2 = 1'b1;
        step();

        // A read at edge 25 restarts the window on port 0: pulse after edge 55
        empty_0 = 1'b0;
        for (int k = 1; k <= 57; k++) begin
            read_enb_0 = (k == 25);
            step();
            check($sformatf("restart0_e%0d", k), {1'b0, soft_reset_2, soft_reset_1, soft_reset_0},
                  {3'b0, (k == 55)});
        end
        read_enb_0 = 1'b0;
        empty_0 = 1'b1;
        step();

        // Reset mid-count on port 1
        load_addr(2'b10);
        empty_1 = 1'b0;
        repeat (20) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        write_enb_reg = 1'b1; #1;
        check("midreset_addr00", {1'b0, write_enb}, 4'h1);
        check("midreset_vld1", {3'b0, vld_out_1}, 4'h1);
        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("midreset1_e%0d", k), {3'b0, soft_reset_1}, {3'b0, (k == TO)});
        end
        empty_1 = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
- Synchronizer/control stage directly upstream of the three router_fifo instances.
- Latches the 2-bit destination address from the packet header and steers the register stage's write strobe to one FIFO as a one-hot write_enb.
- Reports the selected FIFO's full flag back to the FSM and drives vld_out per output port.
- Generates a per-FIFO soft_reset pulse when a valid output sits unread for TIMEOUT cycles.

Parameters:
TIMEOUT, 30, consecutive unread-valid cycles before that port's soft_reset pulses (legal range 2..63)
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  system clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
detect_add  in  1  FSM strobe: header byte present on data_in
data_in  in  2  header address bits [1:0]
write_enb_reg  in  1  FSM write strobe for current byte
read_enb_0/1/2  in  1 each  downstream read enable per port
empty_0/1/2  in  1 each  FIFO empty flags
full_0/1/2  in  1 each  FIFO full flags
write_enb  out  3  one-hot FIFO write enable
fifo_full  out  1  full flag of the addressed FIFO
vld_out_0/1/2  out  1 each  data valid per output port
soft_reset_0/1/2  out  1 each  one-cycle soft reset to each FIFO

Behaviour:
- Address register addr[1:0]:
  - resetn=0 at an edge sets addr=00.
  - Otherwise, detect_add=1 at an edge loads data_in; else addr holds.
- write_enb (combinational from registered addr):
  - write_enb_reg=0 gives 000.
  - With write_enb_reg=1: addr 00→001, 01→010, 10→100, 11→000.
  - detect_add and write_enb_reg high in the same cycle decode the OLD addr; the new address takes effect the following cycle.
- fifo_full (combinational): full_0/full_1/full_2 for addr 00/01/10; 0 for addr 11.
- vld_out_n = ~empty_n (combinational, no latency).
- Per-port timeout logic, n = 0..2, independent:
  - State: counter cnt_n[CNT_W-1:0] and registered soft_reset_n.
  - Reset: cnt_n=0, soft_reset_n=0.
  - vld_out_n=0 → cnt_n=0, soft_reset_n=0.
  - vld_out_n=1 and read_enb_n=1 → cnt_n=0, soft_reset_n=0; any read restarts the window.
  - vld_out_n=1, read_enb_n=0, cnt_n<TIMEOUT-1 → cnt_n+1, soft_reset_n=0.
  - vld_out_n=1, read_enb_n=0, cnt_n==TIMEOUT-1 → cnt_n=0, soft_reset_n=1 for exactly one cycle.
  - Net effect: soft_reset_n is high in the cycle after the TIMEOUT-th consecutive edge with valid and no read.
- soft_reset_n is never high two consecutive cycles.
- If the FIFO is still non-empty after the pulse, counting restarts from 0.
- Reset mid-count:
  - Counters, pulses and addr clear on that edge.
  - Combinational outputs follow inputs immediately.
  - After reset, write_enb decodes addr=00 until a new detect_add.
- No arithmetic overflow: the counter never exceeds TIMEOUT-1.

Optional Feature:
ROUTER_SYNC_ADDR_ERR_EN
- Defined:
  - Adds output addr_err (1 bit, registered, reset 0).
  - At an edge with detect_add=1 and data_in=11, addr_err is set to 1.
  - At an edge with detect_add=1 and a legal address, addr_err clears.
  - While addr_err=1, write_enb is forced to 000 and fifo_full to 0 regardless of write_enb_reg.
- Undefined: no addr_err port; addr 11 simply decodes write_enb=000 and fifo_full=0 as above.

Test Plan:
- Address steering: resetn low 1 cycle.
  - Pulse detect_add with data_in=01 → next cycle write_enb_reg=1 gives write_enb=010.
  - Repeat with 10 → 100 and 00 → 001.
  - data_in=11 → 000.
- Same-cycle update: addr=00; assert detect_add with data_in=10 and write_enb_reg=1 together.
  - That cycle write_enb=001; next cycle (write_enb_reg=1) write_enb=100.
- fifo_full mux: addr=01, full_1=1, full_0=full_2=0 → fifo_full=1.
  - Switch addr to 10 → fifo_full=0.
- Timeout: TIMEOUT=30, empty_2=0, read_enb_2=0 from edge 1.
  - soft_reset_2=1 only in the cycle after edge 30, then 0.
  - Holding empty_2=0 gives the next pulse after edge 60.
- Read restarts window: empty_0=0, read_enb_0=1 at edge 25 only, else 0.
  - No pulse through edge 54; pulse after edge 55.
  - soft_reset_1 and soft_reset_2 stay 0 throughout.
- Reset mid-count: cnt_1 at 20, resetn=0 for one edge, then release with empty_1=0.
  - soft_reset_1 pulses after the 30th edge following release.
  - addr reads 00.
